// File: rtl/led_status_arbiter.sv
// led_status_arbiter
//
// Shares one RGB status LED among four prioritised status sources and is the
// only driver of the LED pins. Each source has its own colour and blink
// pattern, brightness is set by a PWM duty, and a granted source is held on
// the LED for a minimum number of blink ticks so short-lived states remain
// visible. A latched fault preempts everything immediately.
//
// Ports:
//   i_clock          clock
//   i_reset          synchronous, active-high reset
//   i_fault          fault event (level or pulse), latched internally
//   i_fault_clr      clears the latched fault (a simultaneous i_fault wins)
//   i_adc_init_done  ADC initialised; low means init is still pending
//   i_calib_enabled  calibration active
//   i_run_enabled    normal run
//   i_duty           brightness; LED lit while pwm_cnt < i_duty
//   o_led_r/g/b      LED pins (registered)
//   o_grant_id       displayed source: 3 fault, 2 adc, 1 calib, 0 run
//   o_grant_valid    a source is currently displayed

module led_status_arbiter #(
  parameter int PWM_PERIOD  = 50,
  parameter int BLINK_TICKS = 25000000,
  parameter int MIN_HOLD    = 2,
  parameter int DUTY_W      = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_fault,
  input  logic              i_fault_clr,
  input  logic              i_adc_init_done,
  input  logic              i_calib_enabled,
  input  logic              i_run_enabled,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_led_r,
  output logic              o_led_g,
  output logic              o_led_b,
  output logic [1:0]        o_grant_id,
  output logic              o_grant_valid
);

  localparam int PWM_W   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HOLD_W  = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int CMP_W   = (PWM_W > DUTY_W) ? PWM_W : DUTY_W;

  localparam logic [PWM_W-1:0]   PWM_LAST   = PWM_W'(PWM_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  localparam logic [1:0] SRC_RUN   = 2'd0;
  localparam logic [1:0] SRC_CAL   = 2'd1;
  localparam logic [1:0] SRC_ADC   = 2'd2;
  localparam logic [1:0] SRC_FAULT = 2'd3;

  // Highest-index set request; only meaningful when at least one bit is set.
  function automatic logic [1:0] top_req(input logic [3:0] r);
    logic [1:0] p;
    if (r[3]) begin
      p = SRC_FAULT;
    end else if (r[2]) begin
      p = SRC_ADC;
    end else if (r[1]) begin
      p = SRC_CAL;
    end else begin
      p = SRC_RUN;
    end
    return p;
  endfunction

  // State and counters
  logic [PWM_W-1:0]   pwm_cnt_q,   pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]         phase_q,     phase_d;
  logic               fault_q,     fault_d;
  logic [0:0]         state_q,     state_d;
  logic [1:0]         grant_q,     grant_d;
  logic [HOLD_W-1:0]  hold_q,      hold_d;

  // Registered outputs
  logic               led_r_q, led_r_d;
  logic               led_g_q, led_g_d;
  logic               led_b_q, led_b_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;

  logic               blink_tick;
  logic               pwm_on;
  logic [3:0]         req;
  logic [1:0]         req_top;

  assign blink_tick = (blink_cnt_q == BLINK_LAST);
  // Widen both sides so a duty at or above the period keeps the LED fully on.
  assign pwm_on     = (CMP_W'(pwm_cnt_q) < CMP_W'(i_duty));
  assign req        = {fault_q, ~i_adc_init_done, i_calib_enabled, i_run_enabled};
  assign req_top    = top_req(req);

  // Free-running PWM and blink timebase; grant changes never disturb them.
  always_comb begin
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = {PWM_W{1'b0}};
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end
    if (blink_tick) begin
      blink_cnt_d = {BLINK_W{1'b0}};
      phase_d     = phase_q + 2'd1;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q;
    end
  end

  // Fault latch: a new fault beats a clear arriving in the same cycle.
  always_comb begin
    fault_d = fault_q;
    if (i_fault) begin
      fault_d = 1'b1;
    end else if (i_fault_clr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Grant FSM with minimum display time; only a fault may cut a hold short.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_SHOW;
          grant_d = req_top;
          hold_d  = {HOLD_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (req[3] && (grant_q != SRC_FAULT)) begin
          grant_d = SRC_FAULT;
          hold_d  = {HOLD_W{1'b0}};
        end else if (hold_q == HOLD_MAX) begin
          if (req == 4'b0000) begin
            state_d = ST_IDLE;
            hold_d  = {HOLD_W{1'b0}};
          end else if ((req_top != grant_q) || !req[grant_q]) begin
            grant_d = req_top;
            hold_d  = {HOLD_W{1'b0}};
          end else begin
            // Hold satisfied and still the top request: stay, saturated.
            hold_d = hold_q;
          end
        end else if (blink_tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = grant_q;
        hold_d  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // LED colour/pattern map; grant_id keeps its last value while idle.
  always_comb begin
    logic pattern;
    logic lit;
    led_r_d       = 1'b0;
    led_g_d       = 1'b0;
    led_b_d       = 1'b0;
    grant_id_d    = grant_id_q;
    grant_valid_d = 1'b0;
    pattern       = 1'b0;
    lit           = 1'b0;
    case (grant_q)
      SRC_FAULT: pattern = phase_q[0];
      SRC_ADC:   pattern = 1'b1;
      SRC_CAL:   pattern = phase_q[1];
      SRC_RUN:   pattern = 1'b1;
      default:   pattern = 1'b0;
    endcase
    lit = pwm_on & pattern;
    if (state_q == ST_SHOW) begin
      grant_id_d    = grant_q;
      grant_valid_d = 1'b1;
      led_r_d       = lit & ((grant_q == SRC_FAULT) | (grant_q == SRC_ADC));
      led_b_d       = lit & (grant_q == SRC_CAL);
      led_g_d       = lit & (grant_q == SRC_RUN);
    end else begin
      grant_id_d    = grant_id_q;
      grant_valid_d = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pwm_cnt_q     <= {PWM_W{1'b0}};
      blink_cnt_q   <= {BLINK_W{1'b0}};
      phase_q       <= 2'd0;
      fault_q       <= 1'b0;
      state_q       <= ST_IDLE;
      grant_q       <= SRC_RUN;
      hold_q        <= {HOLD_W{1'b0}};
      led_r_q       <= 1'b0;
      led_g_q       <= 1'b0;
      led_b_q       <= 1'b0;
      grant_id_q    <= 2'd0;
      grant_valid_q <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      fault_q       <= fault_d;
      state_q       <= state_d;
      grant_q       <= grant_d;
      hold_q        <= hold_d;
      led_r_q       <= led_r_d;
      led_g_q       <= led_g_d;
      led_b_q       <= led_b_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign o_led_r       = led_r_q;
  assign o_led_g       = led_g_q;
  assign o_led_b       = led_b_q;
  assign o_grant_id    = grant_id_q;
  assign o_grant_valid = grant_valid_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Testbench for led_status_arbiter: a behavioural reference model predicts the
// pins for every clock; predictions are queued when stimulus is applied and
// compared once the DUT has clocked. Directed checks cover the named
// scenarios with constant expectations.

module tb_led_status_arbiter;

  localparam int PP = 10;
  localparam int BT = 4;
  localparam int MH = 2;
  localparam int DW = 8;

  logic          i_clock;
  logic          i_reset;
  logic          i_fault;
  logic          i_fault_clr;
  logic          i_adc_init_done;
  logic          i_calib_enabled;
  logic          i_run_enabled;
  logic [DW-1:0] i_duty;
  logic          o_led_r;
  logic          o_led_g;
  logic          o_led_b;
  logic [1:0]    o_grant_id;
  logic          o_grant_valid;

  led_status_arbiter #(
    .PWM_PERIOD (PP),
    .BLINK_TICKS(BT),
    .MIN_HOLD   (MH),
    .DUTY_W     (DW)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_fault        (i_fault),
    .i_fault_clr    (i_fault_clr),
    .i_adc_init_done(i_adc_init_done),
    .i_calib_enabled(i_calib_enabled),
    .i_run_enabled  (i_run_enabled),
    .i_duty         (i_duty),
    .o_led_r        (o_led_r),
    .o_led_g        (o_led_g),
    .o_led_b        (o_led_b),
    .o_grant_id     (o_grant_id),
    .o_grant_valid  (o_grant_valid)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic       r;
    logic       g;
    logic       b;
    logic       v;
    logic [1:0] gid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_pwm = 0, m_blink = 0, m_phase = 0, m_fault = 0;
  int m_show = 0, m_grant = 0, m_hold = 0, m_gid = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Predict the pins after the coming edge from the current inputs.
  task automatic model_step();
    exp_t e;
    int   req[4];
    int   p;
    bit   tick, pon, lit;
    e = '{r: 1'b0, g: 1'b0, b: 1'b0, v: 1'b0, gid: 2'd0};
    if (i_reset) begin
      m_pwm = 0; m_blink = 0; m_phase = 0; m_fault = 0;
      m_show = 0; m_grant = 0; m_hold = 0; m_gid = 0;
    end else begin
      tick = (m_blink == BT - 1);
      pon  = (m_pwm < int'(i_duty));
      if (m_show != 0) begin
        case (m_grant)
          3: lit = (m_phase % 2) == 1;
          1: lit = (m_phase / 2) == 1;
          default: lit = 1'b1;
        endcase
        lit   = lit && pon;
        e.r   = lit && (m_grant >= 2);
        e.b   = lit && (m_grant == 1);
        e.g   = lit && (m_grant == 0);
        e.v   = 1'b1;
        m_gid = m_grant;
      end
      e.gid = 2'(m_gid);
      req[3] = m_fault;
      req[2] = i_adc_init_done ? 0 : 1;
      req[1] = i_calib_enabled ? 1 : 0;
      req[0] = i_run_enabled ? 1 : 0;
      p = -1;
      for (int i = 0; i < 4; i++) if (req[i] != 0) p = i;
      if (m_show == 0) begin
        if (p >= 0) begin m_show = 1; m_grant = p; m_hold = 0; end
      end else if (req[3] != 0 && m_grant != 3) begin
        m_grant = 3; m_hold = 0;
      end else if (m_hold == MH) begin
        if (p < 0) begin
          m_show = 0; m_hold = 0;
        end else if (p != m_grant || req[m_grant] == 0) begin
          m_grant = p; m_hold = 0;
        end
      end else if (tick) begin
        m_hold++;
      end
      if (i_fault) m_fault = 1;
      else if (i_fault_clr) m_fault = 0;
      m_pwm   = (m_pwm + 1) % PP;
      m_blink = (m_blink + 1) % BT;
      if (tick) m_phase = (m_phase + 1) % 4;
    end
    exp_q.push_back(e);
  endtask

  // One clock: predict, clock the DUT, then compare away from the edge.
  task automatic step();
    exp_t e;
    model_step();
    @(posedge i_clock);
    #1;
    e = exp_q.pop_front();
    check("led_r", o_led_r, e.r);
    check("led_g", o_led_g, e.g);
    check("led_b", o_led_b, e.b);
    check("valid", o_grant_valid, e.v);
    check("grant_id", o_grant_id, e.gid);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_gid(input logic [1:0] want, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (o_grant_valid && o_grant_id == want) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  task automatic count_leds(input int n, output int cr, output int cg, output int cb);
    cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cr += int'(o_led_r);
      cg += int'(o_led_g);
      cb += int'(o_led_b);
    end
  endtask

  initial begin
    int cr, cg, cb;
    i_reset = 1'b1; i_fault = 1'b0; i_fault_clr = 1'b0;
    i_adc_init_done = 1'b1; i_calib_enabled = 1'b0; i_run_enabled = 1'b0;
    i_duty = 8'd5;
    #2;
    run(2);
    check("rst_valid", o_grant_valid, 0);
    check("rst_gid", o_grant_id, 0);

    // 1: ADC init pending -> red steady at 50% duty, grant visible on cycle 2
    i_reset = 1'b0;
    i_adc_init_done = 1'b0;
    run(2);
    check("t1_gid", o_grant_id, 2);
    check("t1_valid", o_grant_valid, 1);
    count_leds(10, cr, cg, cb);
    check("t1_r_on", cr, 5);
    check("t1_gb_off", cg + cb, 0);

    // 2: calibration waits for the hold, then blinks blue slowly
    i_adc_init_done = 1'b1;
    i_calib_enabled = 1'b1;
    step();
    check("t2_still_adc", o_grant_id, 2);
    wait_gid(2'd1, 20, "t2_to_calib");
    run(20);

    // 3: one-cycle fault pulse preempts calibration and stays latched
    i_calib_enabled = 1'b0;
    i_run_enabled = 1'b1;
    wait_gid(2'd0, 20, "t3_to_run");
    i_run_enabled = 1'b0;
    i_calib_enabled = 1'b1;
    wait_gid(2'd1, 20, "t3_to_calib");
    i_fault = 1'b1;
    step();
    i_fault = 1'b0;
    wait_gid(2'd3, 4, "t3_fault");
    run(16);
    check("t3_fault_held", o_grant_id, 3);

    // 4: simultaneous set/clear keeps fault; clear alone hands back to calib
    i_fault = 1'b1; i_fault_clr = 1'b1;
    step();
    i_fault = 1'b0; i_fault_clr = 1'b0;
    run(12);
    check("t4_set_wins", o_grant_id, 3);
    i_fault_clr = 1'b1;
    step();
    i_fault_clr = 1'b0;
    wait_gid(2'd1, 20, "t4_to_calib");

    // 5: requests drop under run -> held, then idle with grant_id kept
    i_calib_enabled = 1'b0;
    i_run_enabled = 1'b1;
    wait_gid(2'd0, 20, "t5_to_run");
    i_run_enabled = 1'b0;
    step();
    check("t5_held_valid", o_grant_valid, 1);
    run(12);
    check("t5_idle_valid", o_grant_valid, 0);
    check("t5_idle_gid", o_grant_id, 0);
    count_leds(5, cr, cg, cb);
    check("t5_idle_dark", cr + cg + cb, 0);

    // 6: duty extremes and reset in the middle of SHOW
    i_duty = 8'd0;
    i_run_enabled = 1'b1;
    count_leds(20, cr, cg, cb);
    check("t6_duty0_dark", cr + cg + cb, 0);
    i_duty = 8'd12;
    run(3);
    count_leds(10, cr, cg, cb);
    check("t6_full_on", cg, 10);
    i_reset = 1'b1;
    step();
    check("t6_rst_valid", o_grant_valid, 0);
    check("t6_rst_leds", {o_led_r, o_led_g, o_led_b}, 0);
    check("t6_rst_gid", o_grant_id, 0);
    i_reset = 1'b0;
    run(10);

    // Randomised traffic against the model
    i_duty = 8'd5;
    for (int i = 0; i < 300; i++) begin
      if (i % 8 == 0) begin
        i_adc_init_done = ($urandom_range(0, 3) != 0);
        i_calib_enabled = $urandom_range(0, 1) == 1;
        i_run_enabled   = $urandom_range(0, 1) == 1;
        i_duty          = 8'($urandom_range(0, 12));
      end
      i_fault     = ($urandom_range(0, 30) == 0);
      i_fault_clr = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_status_arbiter.md
Name: led_status_arbiter

Overview:
- Shares the single RGB status LED among four prioritized status sources: fault, ADC-init pending, calibration, running.
- Applies a per-source colour and blink pattern, PWM brightness dimming, and a minimum display time so short-lived states stay visible.
- Sits between the top-level status signals and the LED pins; it is the sole driver of o_led_r/g/b.

Parameters:
PWM_PERIOD, 50, PWM period in clocks; pwm_cnt wraps at PWM_PERIOD-1.
BLINK_TICKS, 25000000, clocks per blink tick.
MIN_HOLD, 2, minimum blink ticks a granted source is displayed before a non-fault switch.
DUTY_W, 8, width of i_duty.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_fault  in  1  fault event, level or pulse; latched
i_fault_clr  in  1  clears the latched fault
i_adc_init_done  in  1  ADC initialised; low means init is pending
i_calib_enabled  in  1  calibration active
i_run_enabled  in  1  normal run
i_duty  in  DUTY_W  brightness; LED on while pwm_cnt < i_duty
o_led_r  out  1  red LED
o_led_g  out  1  green LED
o_led_b  out  1  blue LED
o_grant_id  out  2  displayed source: 3 fault, 2 adc, 1 calib, 0 run
o_grant_valid  out  1  a source is displayed

Behaviour:
- Reset is i_reset, synchronous, active-high, on clock i_clock. Reset clears all counters and fault_q, sets state IDLE, and drives every output to 0.
- PWM counter:
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps to 0.
  - pwm_on = (pwm_cnt < i_duty).
  - i_duty=0 gives always off; i_duty>=PWM_PERIOD gives always on.
- Blink timing:
  - blink_cnt counts 0..BLINK_TICKS-1. blink_tick is a one-cycle pulse in the cycle blink_cnt wraps.
  - phase[1:0] increments on each blink_tick.
  - fast = phase[0]; slow = phase[1].
  - Both counters are free-running and are never reset by a grant change.
- Fault latch:
  - fault_q sets when i_fault=1.
  - fault_q clears when i_fault_clr=1 and i_fault=0.
  - If both are asserted in the same cycle, set wins.
- Requests: req[3]=fault_q, req[2]=~i_adc_init_done, req[1]=i_calib_enabled, req[0]=i_run_enabled. The highest index has priority.
- Source map (colour, pattern):
  - 3: red, fast blink.
  - 2: red, steady.
  - 1: blue, slow blink.
  - 0: green, steady.
- FSM states: IDLE, SHOW.
- IDLE:
  - If any req is set, go to SHOW next cycle with grant = highest req and hold_cnt = 0.
- SHOW (current grant g):
  - hold_cnt increments on each blink_tick and saturates at MIN_HOLD.
  - Preemption: if req[3] is set and g!=3, take grant=3 next cycle and set hold_cnt=0, regardless of hold_cnt.
  - Otherwise, when hold_cnt==MIN_HOLD:
    - If p, the highest set req, differs from g, or g's own request has dropped: grant p and set hold_cnt=0.
    - If no req is set, go to IDLE.
  - While hold_cnt<MIN_HOLD, g stays displayed even if its request has dropped.
  - A lower-priority source never preempts. A higher non-fault source waits until hold completes.
- Outputs are registered, so there is 1-cycle latency from pwm_cnt/phase/state to the pins.
  - Lit = pwm_on AND pattern (steady = 1).
  - Only the mapped colour is driven; the other colours are 0.
  - In IDLE, all LEDs = 0 and o_grant_valid = 0.
  - o_grant_id holds its last value in IDLE.
- Reset mid-operation discards the latched fault and the hold state. The first grant after reset follows the IDLE rule.

Test Plan:
Use PWM_PERIOD=10, BLINK_TICKS=4, MIN_HOLD=2, i_duty=5 throughout.
1. Reset, then adc_init_done=0 -> cycle 2: grant_id=2, valid=1. o_led_r high for exactly 5 of every 10 cycles; g and b stay 0.
2. adc_init_done=1, calib=1 while grant=2 -> grant stays 2 until 2 blink ticks (8 clocks) after grant, then grant=1. b PWM is gated by phase[1] (on 8 clocks, off 8 clocks).
3. calib=1 granted with hold_cnt=0, then i_fault one-cycle pulse -> grant=3 within 2 cycles. Red toggles every 4 clocks and stays so after the pulse ends.
4. i_fault_clr=1 with i_fault=1 in the same cycle -> fault_q stays 1. Then i_fault_clr alone -> after hold completes, grant falls to the highest remaining request.
5. All requests drop while granted source 0 -> LED stays on until hold_cnt=2, then IDLE: all LEDs 0, valid=0, grant_id unchanged.
6. i_duty=0 -> LEDs never high; i_duty=12 -> steady source lit every cycle; assert i_reset mid-SHOW -> next cycle all outputs 0 and state IDLE.
